// File: rtl/gat_layer_scheduler.sv
// Layer sequencer for the GAT core: BRAM loads, watchdog-supervised compute, readback.
// Optional perf counters are built when GAT_SCHED_PERF_EN is defined.
module gat_layer_scheduler #(
  parameter int          NUM_LAYERS     = 2,
  parameter int          TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 load_req,
  output logic [1:0]           load_sel,
  input  logic                 load_ack,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  output logic                 gat_layer,
  input  logic                 gat_ready,
  output logic                 rd_req,
  input  logic                 rd_ack,
  output logic [1:0]           layer_idx,
`ifdef GAT_SCHED_PERF_EN
  output logic [31:0]          perf_total,
  output logic [31:0]          perf_load,
`endif
  output logic [TIMEOUT_W-1:0] run_cycles
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_H, S_LD_NI, S_LD_W, S_RUN, S_READ, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LIMIT   = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]           LAST_LAYER = 2'(NUM_LAYERS - 1);

  state_t                state_q, state_n;
  logic                  gap_q, gap_n;
  logic                  h_q, h_n, ni_q, ni_n, w_q, w_n;
  logic                  gl_q, gl_n;
  logic [1:0]            layer_q, layer_n;
  logic [TIMEOUT_W-1:0]  rc_q, rc_n, rc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      h_q     <= 1'b0;
      ni_q    <= 1'b0;
      w_q     <= 1'b0;
      gl_q    <= 1'b0;
      layer_q <= 2'd0;
      rc_q    <= '0;
    end else begin
      state_q <= state_n;
      gap_q   <= gap_n;
      h_q     <= h_n;
      ni_q    <= ni_n;
      w_q     <= w_n;
      gl_q    <= gl_n;
      layer_q <= layer_n;
      rc_q    <= rc_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    gap_n    = 1'b0;
    h_n      = h_q;
    ni_n     = ni_q;
    w_n      = w_q;
    gl_n     = gl_q;
    layer_n  = layer_q;
    rc_n     = rc_q;
    load_req = 1'b0;
    load_sel = 2'd0;
    rd_req   = 1'b0;
    rc_inc   = (rc_q < TO_LIMIT) ? rc_q + TIMEOUT_W'(1) : rc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_LD_H;
          h_n     = 1'b0;
          ni_n    = 1'b0;
          w_n     = 1'b0;
          gl_n    = 1'b0;
          layer_n = 2'd0;
        end
      end
      S_LD_H: begin
        load_req = 1'b1;
        if (load_ack) begin
          h_n     = 1'b1;
          gap_n   = 1'b1;
          state_n = S_LD_NI;
        end
      end
      // gap_q holds the request low for the single cycle after the previous ack
      S_LD_NI: begin
        load_sel = 2'd1;
        load_req = !gap_q;
        if (!gap_q && load_ack) begin
          ni_n    = 1'b1;
          gap_n   = 1'b1;
          state_n = S_LD_W;
        end
      end
      S_LD_W: begin
        load_sel = 2'd2;
        load_req = !gap_q;
        if (!gap_q && load_ack) begin
          w_n     = 1'b1;
          rc_n    = '0;
          state_n = S_RUN;
        end
      end
      // rc_q is zero only on the entry cycle, so that cycle ignores gat_ready
      S_RUN: begin
        rc_n = rc_inc;
        if (rc_q != '0 && gat_ready) state_n = S_READ;
        else if (rc_inc >= TO_LIMIT) state_n = S_ERR;
      end
      S_READ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          w_n     = 1'b0;
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (layer_q == LAST_LAYER) begin
          state_n = S_DONE;
        end else begin
          layer_n = layer_q + 2'd1;
          gl_n    = 1'b1;
          state_n = S_LD_W;
        end
      end
      default: ;
    endcase

    if (abort) begin
      state_n = S_IDLE;
      gap_n   = 1'b0;
      h_n     = 1'b0;
      ni_n    = 1'b0;
      w_n     = 1'b0;
      gl_n    = 1'b0;
      layer_n = 2'd0;
      rc_n    = rc_q;
    end
  end

  assign busy  = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done  = (state_q == S_DONE);
  assign error = (state_q == S_ERR);
  assign h_data_bram_load_done      = h_q;
  assign h_node_info_bram_load_done = ni_q;
  assign wgt_bram_load_done         = w_q;
  assign gat_layer  = gl_q;
  assign layer_idx  = layer_q;
  assign run_cycles = rc_q;

`ifdef GAT_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      perf_total <= '0;
      perf_load  <= '0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      perf_total <= '0;
      perf_load  <= '0;
    end else if (busy) begin
      if (perf_total != '1) perf_total <= perf_total + 32'd1;
      if (state_q inside {S_LD_H, S_LD_NI, S_LD_W} && perf_load != '1)
        perf_load <= perf_load + 32'd1;
    end
  end
`endif

endmodule

// File: doc/gat_layer_scheduler.md
Name: gat_layer_scheduler

Overview:
- Top-level sequencer for the GAT accelerator core. Runs a multi-layer inference as: per-layer BRAM loads via host/DMA handshakes, the layer-done/load-done flags the core consumes, a watchdog-supervised compute run, then a feature readback handshake.
- Sits between the register bank / DMA front-end and the GAT core's gat_layer, *_load_done and gat_ready pins.

Parameters:
- NUM_LAYERS, 2, layers per inference (1..4).
- TIMEOUT_W, 24, width of the run watchdog counter.
- TIMEOUT_CYCLES, 16777215, max RUN cycles before error (must fit TIMEOUT_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin inference; ignored unless state is IDLE or DONE.
- abort  in  1  one-cycle pulse: return to IDLE from any state.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  high in DONE.
- error  out  1  high in ERR.
- load_req  out  1  request DMA to fill one BRAM.
- load_sel  out  2  0 = H data, 1 = node info, 2 = weights.
- load_ack  in  1  DMA finished the selected BRAM.
- h_data_bram_load_done  out  1  to core.
- h_node_info_bram_load_done  out  1  to core.
- wgt_bram_load_done  out  1  to core.
- gat_layer  out  1  layer index to core: 0 for layer 0, 1 for any later layer.
- gat_ready  in  1  core layer-complete level.
- rd_req  out  1  request host readback of layer output.
- rd_ack  in  1  host readback complete.
- layer_idx  out  2  current layer.
- run_cycles  out  TIMEOUT_W  watchdog count of the last or current RUN.

Behaviour:
- Reset: all outputs 0, state IDLE, layer_idx 0, run_cycles 0.
- States: IDLE, LD_H, LD_NI, LD_W, RUN, READ, NEXT, DONE, ERR.

Transitions:
- IDLE/DONE + start -> LD_H. Clear done, layer_idx and all three load_done flags.
- LD_H: load_req=1, load_sel=0. On load_ack, the next cycle sets h_data_bram_load_done, drops load_req for one cycle, and moves to LD_NI.
- LD_NI: load_sel=1, same handshake; sets h_node_info_bram_load_done, then moves to LD_W.
- LD_W: load_sel=2, same handshake; sets wgt_bram_load_done, then moves to RUN.
- RUN: run_cycles clears on entry and increments each cycle. gat_ready is ignored on the entry cycle.
  - gat_ready=1 on any later cycle -> READ.
  - run_cycles reaching TIMEOUT_CYCLES -> ERR.
- READ: rd_req=1 until rd_ack is sampled, then -> NEXT (rd_req drops the same cycle as the transition).
- NEXT (one cycle):
  - Clear wgt_bram_load_done.
  - If layer_idx == NUM_LAYERS-1 -> DONE.
  - Otherwise increment layer_idx, set gat_layer=1, and go to LD_W. H-data and node-info flags stay high; later layers reload weights only.
- DONE: done=1 and the flags hold until start or abort.
- ERR: error=1, load_req and rd_req = 0. Leaves only on abort or rst; start is ignored.
- abort in any state: next cycle is IDLE with all outputs as at reset, except run_cycles, which holds.
- Handshake rules:
  - load_ack / rd_ack are sampled only while the matching req is high; strays are ignored.
  - load_sel is stable the whole time load_req is high.
  - Requests are levels held until ack.
- Simultaneous events:
  - abort beats any ack, start, gat_ready or timeout in the same cycle.
  - gat_ready and timeout in the same cycle -> READ (completion wins).
  - rst beats everything.
- run_cycles saturates at TIMEOUT_CYCLES and never wraps.
- gat_layer changes only in NEXT or on start, abort or rst, never during RUN.

Optional Feature:
- GAT_SCHED_PERF_EN defined:
  - Adds output perf_total (32 bits): cycles from start to DONE, cleared on start, saturating at 2^32-1, holds in DONE/ERR.
  - Adds output perf_load (32 bits): cumulative cycles spent in LD_* states.
- Not defined: neither port exists and no counters are synthesised.

Test Plan:
- Nominal 2-layer run:
  - Stimulus: start, then ack each load after 5 cycles, gat_ready 100 cycles into each RUN, rd_ack after 3 cycles.
  - Required: load_sel sequence 0,1,2,2; gat_layer 0 then 1; run_cycles=100 after each RUN; done=1; busy=0.
- Layer-1 flags:
  - Required: wgt_bram_load_done low for exactly the NEXT cycle plus the LD_W time.
  - Required: h_data_bram_load_done and h_node_info_bram_load_done stay 1 throughout.
- Timeout:
  - Stimulus: build with TIMEOUT_CYCLES=50; gat_ready never asserts.
  - Required: error=1 after 50 RUN cycles; load_req and rd_req = 0; a following start is ignored; abort returns to IDLE.
- Abort vs ack:
  - Stimulus: abort and load_ack in the same cycle during LD_NI.
  - Required: next state IDLE, all load_done flags = 0, node-info flag never set.
- Stray and same-cycle inputs:
  - Stimulus: rd_ack during RUN, load_ack during IDLE, start while busy.
  - Required: no state change.
  - Stimulus: gat_ready on the RUN entry cycle.
  - Required: it is ignored.
- Timeout/ready tie:
  - Stimulus: gat_ready and timeout in the same cycle.
  - Required: state goes to READ, error stays 0.
